// File: rtl/rotdec_pkg.sv
// Shared types and rotate helpers for the rotate_decoder block.
// Optional build macro: ROTDEC_BIDIR_EN (see rotate_decoder.sv).
package rotdec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Widest word the helpers below can rotate.
  localparam int ROT_MAX_W  = 64;
  localparam int ROT_IDX_W  = $clog2(ROT_MAX_W);

  // Rotate the low 'width' bits of word left by 'amount'; upper bits return 0.
  function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] word,
                                                input int amount, input int width);
    logic [ROT_MAX_W-1:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < ROT_MAX_W; i++) begin
      if (i < width) begin
        idx = (i + amount) % width;
        r[idx[ROT_IDX_W-1:0]] = word[i];
      end
    end
    return r;
  endfunction

  // Rotate the low 'width' bits of word right by 'amount'; upper bits return 0.
  function automatic logic [ROT_MAX_W-1:0] rotr(input logic [ROT_MAX_W-1:0] word,
                                                input int amount, input int width);
    logic [ROT_MAX_W-1:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < ROT_MAX_W; i++) begin
      if (i < width) begin
        idx = (i + amount) % width;
        r[i] = word[idx[ROT_IDX_W-1:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rotate_decoder_rotate_unit.sv
// rotate_unit: combinational WIDTH-bit rotator (dir 0 = left, 1 = right).
module rotate_unit
  import rotdec_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         d,
  input  logic [$clog2(WIDTH)-1:0] s,
  input  logic                     dir,
  output logic [WIDTH-1:0]         y
);

  logic [ROT_MAX_W-1:0] d_wide;

  assign d_wide = ROT_MAX_W'(d);

  // Select the rotate direction; only the low WIDTH bits of the helper result are meaningful.
  assign y = dir ? WIDTH'(rotr(d_wide, int'(s), WIDTH))
                 : WIDTH'(rotl(d_wide, int'(s), WIDTH));

endmodule

// File: rtl/rotate_decoder.sv
// rotate_decoder: searches for the smallest rotate amount k that maps the
// latched word d onto the latched word y, one candidate k per clock.
// Build macro ROTDEC_BIDIR_EN: also test right rotations each step and
// limit the search to k = 0..WIDTH/2 (left wins ties at equal k).
module rotate_decoder
  import rotdec_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         d_in,
  input  logic [WIDTH-1:0]         y_in,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [$clog2(WIDTH)-1:0] amt,
  output logic                     dir
);

  localparam int SW = $clog2(WIDTH);

`ifdef ROTDEC_BIDIR_EN
  localparam logic [SW:0] K_LAST = (SW+1)'(WIDTH / 2);
`else
  localparam logic [SW:0] K_LAST = (SW+1)'(WIDTH - 1);
`endif

  generate
    if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0) || (WIDTH > ROT_MAX_W)) begin : g_bad_width
      $error("rotate_decoder: WIDTH must be a power of two between 2 and ROT_MAX_W");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] y_q;
  // One extra bit so the step after the terminal count does not wrap to 0.
  logic [SW:0]      k;
  logic [WIDTH-1:0] rot_l;
  logic             match_l;
  logic             match_r;

  rotate_unit #(.WIDTH(WIDTH)) u_rot_left (
    .d  (d_q),
    .s  (k[SW-1:0]),
    .dir(1'b0),
    .y  (rot_l)
  );

  assign match_l = (rot_l == y_q);

`ifdef ROTDEC_BIDIR_EN
  logic [WIDTH-1:0] rot_r;

  rotate_unit #(.WIDTH(WIDTH)) u_rot_right (
    .d  (d_q),
    .s  (k[SW-1:0]),
    .dir(1'b1),
    .y  (rot_r)
  );

  assign match_r = (rot_r == y_q);
`else
  assign match_r = 1'b0;
`endif

  // Control FSM with registered busy/done/result outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      d_q   <= '0;
      y_q   <= '0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      found <= 1'b0;
      amt   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_q   <= d_in;
            y_q   <= y_in;
            k     <= '0;
            found <= 1'b0;
            amt   <= '0;
            dir   <= 1'b0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          k <= k + 1'b1;
          if (match_l) begin
            found <= 1'b1;
            amt   <= k[SW-1:0];
            dir   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (match_r) begin
            found <= 1'b1;
            amt   <= k[SW-1:0];
            dir   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (k == K_LAST) begin
            found <= 1'b0;
            amt   <= '0;
            dir   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rotate_decoder.md
ROTATE_DECODER -- requirements
Module: rotate_decoder

Interface
REQ-001 Parameter WIDTH, default 4, meaning word width; the block SHALL accept only power-of-two values of 2 or more.
REQ-002 Derived constant SW = clog2(WIDTH), meaning the rotate-amount width; the block SHALL derive it and SHALL NOT expose it as a port.
REQ-003 Port clk, input, 1 bit, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, meaning reset; the block SHALL treat it as asynchronous and active-high.
REQ-005 Port start, input, 1 bit, meaning request a decode of d_in/y_in.
REQ-006 Port d_in, input, WIDTH bits, meaning the original (unrotated) word.
REQ-007 Port y_in, input, WIDTH bits, meaning the rotated word to analyse.
REQ-008 Port busy, output, 1 bit, meaning a search is in progress.
REQ-009 Port done, output, 1 bit, meaning a one-cycle result-valid pulse.
REQ-010 Port found, output, 1 bit, meaning y_in is a rotation of d_in.
REQ-011 Port amt, output, SW bits, meaning the recovered rotate amount.
REQ-012 Port dir, output, 1 bit, meaning the recovered direction (0 = left, 1 = right), matching the rotator's dir encoding.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SEARCH and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch d_in and y_in, clear the step counter k to 0 and enter SEARCH; start SHALL be ignored in every other state.
REQ-015 In SEARCH, each cycle SHALL compare the latched y against rotl(d,k), then increment k.
REQ-016 On the first match, the block SHALL register found=1, amt=k and dir=0, then enter DONE; the smallest k SHALL win, so a periodic word (e.g. 1010) with y=d SHALL report amt=0.
REQ-017 If no match occurs through k=WIDTH-1, the block SHALL register found=0, amt=0 and dir=0, then enter DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-019 busy SHALL be 1 in SEARCH and DONE and 0 in IDLE.
REQ-020 found, amt and dir SHALL hold their value until the next accepted start, which SHALL clear them to 0.
REQ-021 Latency: with start sampled at edge T, the block SHALL assert done in cycle T+2+k on a match at step k, and in cycle T+1+WIDTH when there is no match.
REQ-022 Inputs changing after acceptance SHALL NOT affect the running search.
REQ-023 The counter k SHALL be SW+1 bits wide so that its terminal count does not wrap.

Reset
REQ-024 When rst is asserted, the block SHALL enter IDLE immediately, with k=0, busy=0, done=0, found=0, amt=0, dir=0 and latched words=0.
REQ-025 When rst is asserted mid-SEARCH, the block SHALL abort the search with no done pulse, and on release SHALL accept start on the first clock edge.

Configuration
REQ-026 When the macro ROTDEC_BIDIR_EN is defined, each SEARCH cycle SHALL compare both rotl(d,k) and rotr(d,k), and k SHALL span 0..WIDTH/2.
REQ-027 With ROTDEC_BIDIR_EN defined, a left match SHALL take priority over a right match at the same k, a right match SHALL report dir=1 and amt=k, and the no-match done SHALL occur in cycle T+2+WIDTH/2.
REQ-028 When ROTDEC_BIDIR_EN is undefined, the block SHALL behave as left-only per REQ-015 to REQ-021, and the right-rotate comparator SHALL NOT be instantiated.

Structure
REQ-029 Package rotdec_pkg SHALL hold the state enum (IDLE/SEARCH/DONE) and the functions rotl/rotr(word, amount).
REQ-030 The design SHALL contain one sub-module, rotate_unit, a combinational WIDTH-bit rotator with d, s and dir inputs and a y output, instantiated once per compared direction.

Verification
REQ-031 Test: WIDTH=4, d=1011, y=1101, start at T, left-only -> done at T+5 with found=1, amt=3, dir=0; with ROTDEC_BIDIR_EN -> done at T+3 with found=1, amt=1, dir=1.
REQ-032 Test: d=1011, y=0111 -> found=1, amt=1, dir=0, done at T+3 in both configurations.
REQ-033 Test: d=1010, y=1010 -> found=1, amt=0, dir=0, done at T+2.
REQ-034 Test: d=1011, y=0000 -> found=0, amt=0; done at T+5 left-only and at T+4 with ROTDEC_BIDIR_EN.
REQ-035 Test: start pulsed again while busy, with new d/y -> the first result is unchanged and only one done pulse occurs.
REQ-036 Test: rst asserted at T+2 during a search -> busy=0 immediately with no done pulse; a start after release decodes d=1011, y=1110 -> amt=2, dir=0.
